snes_pad_reader: RTL and testbench

Parametrised serial game-pad reader and successor to the single SNES pad front end. It drives one shared latch/clock pair to NUM_PADS daisy-wired pads, each with its own data line, and polls them at a fixed frame rate. It publishes a stable per-pad button snapshot. It also emits press and release events through a valid/ready stream, which the keyboard-mapping logic consumes instead of a fixed priority decode.

---
 rtl/snes_pad_reader.sv | 166 ++++++++++++++++
 tb/tb_snes_pad_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_reader.sv
// Serial SNES/NES game-pad reader: polls NUM_PADS pads over one shared latch/clock pair,
// publishes a per-pad button snapshot and streams press/release events over valid/ready.
module snes_pad_reader #(
  parameter int NUM_PADS           = 2,
  parameter int NUM_BITS           = 16,
  parameter int HALF_BIT_CYCLES    = 151,
  parameter int LATCH_HALF_PERIODS = 2,
  parameter int POLL_CYCLES        = 418750,
  localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
  localparam int BTN_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_clk,
  output logic                         pad_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         frame_done,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [PAD_W-1:0]             ev_pad,
  output logic [BTN_W-1:0]             ev_button,
  output logic                         ev_pressed,
  output logic                         overflow
);
  localparam int TOT          = NUM_PADS * NUM_BITS;
  localparam int IDX_W        = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int LATCH_CYCLES = LATCH_HALF_PERIODS * HALF_BIT_CYCLES;
  localparam int HC_MAX       = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int HC_W         = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;
  localparam int PC_W         = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  logic [1:0]                         state;
  logic [PC_W-1:0]                    poll_cnt;
  logic [HC_W-1:0]                    hcnt;
  logic [BTN_W-1:0]                   bit_k;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  shadow;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  shadow_next;
  logic [TOT-1:0]                     prev;
  logic [IDX_W-1:0]                   scan_idx;
  logic [PAD_W-1:0]                   emit_pad;
  logic [BTN_W-1:0]                   emit_bit;
  logic                               tick;
  logic                               half_end;
  logic                               latch_end;
  logic                               capture;
  logic                               emit_step;

  assign tick      = (poll_cnt == PC_W'(POLL_CYCLES - 1));
  assign half_end  = (hcnt == HC_W'(HALF_BIT_CYCLES - 1));
  assign latch_end = (hcnt == HC_W'(LATCH_CYCLES - 1));
  assign capture   = (state == ST_SHIFT) && pad_clk && half_end;
  assign emit_step = (state == ST_EMIT) &&
                     (ev_valid ? ev_ready : (buttons[scan_idx] == prev[scan_idx]));

  // Each pad shifts its inverted data in from the top, so the first bit read lands in bit 0.
  for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_shadow
    assign shadow_next[gp] = {~pad_data[gp], shadow[gp][NUM_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (capture) shadow <= shadow_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) poll_cnt <= '0;
    else     poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pad_clk    <= 1'b1;
      pad_latch  <= 1'b0;
      buttons    <= '0;
      prev       <= '0;
      frame_done <= 1'b0;
      ev_valid   <= 1'b0;
      ev_pad     <= '0;
      ev_button  <= '0;
      ev_pressed <= 1'b0;
      overflow   <= 1'b0;
      hcnt       <= '0;
      bit_k      <= '0;
      scan_idx   <= '0;
      emit_pad   <= '0;
      emit_bit   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tick && state != ST_IDLE) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state     <= ST_LATCH;
            pad_latch <= 1'b1;
            hcnt      <= '0;
          end
        end
        ST_LATCH: begin
          if (latch_end) begin
            state     <= ST_SHIFT;
            pad_latch <= 1'b0;
            hcnt      <= '0;
            bit_k     <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!half_end) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (pad_clk) begin
              pad_clk <= 1'b0;
            end else begin
              pad_clk <= 1'b1;
              if (bit_k == BTN_W'(NUM_BITS - 1)) begin
                buttons    <= shadow;
                frame_done <= 1'b1;
                state      <= ST_EMIT;
                scan_idx   <= '0;
                emit_pad   <= '0;
                emit_bit   <= '0;
              end else begin
                bit_k <= bit_k + 1'b1;
              end
            end
          end
        end
        default: begin
          if (ev_valid) begin
            if (ev_ready) begin
              ev_valid       <= 1'b0;
              prev[scan_idx] <= buttons[scan_idx];
            end
          end else if (buttons[scan_idx] != prev[scan_idx]) begin
            ev_valid   <= 1'b1;
            ev_pad     <= emit_pad;
            ev_button  <= emit_bit;
            ev_pressed <= buttons[scan_idx];
          end
        end
      endcase
      // Scan position advances once per unchanged bit or per accepted event.
      if (emit_step) begin
        if (scan_idx == IDX_W'(TOT - 1)) begin
          state <= ST_IDLE;
        end else begin
          scan_idx <= scan_idx + 1'b1;
          if (emit_bit == BTN_W'(NUM_BITS - 1)) begin
            emit_bit <= '0;
            emit_pad <= emit_pad + 1'b1;
          end else begin
            emit_bit <= emit_bit + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_snes_pad_reader.sv
// Directed bench for snes_pad_reader: a 2-pad SNES instance and a 1-pad NES instance
// driven by behavioural pad shift-register models.
module tb_snes_pad_reader;
  localparam int NB = 16;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [31:0] exp;
    int          nev;
  } vec_t;

  typedef struct {
    int pad;
    int btn;
    int pr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pad_data;
  logic        pad_clk, pad_latch, frame_done, ev_valid, ev_pressed, overflow;
  logic        ev_ready = 1'b1;
  logic [31:0] buttons;
  logic [0:0]  ev_pad;
  logic [3:0]  ev_button;

  logic [0:0]  n_data;
  logic        n_clk, n_latch, n_fd, n_valid, n_pressed, n_ovf;
  logic        n_ready = 1'b1;
  logic [7:0]  n_buttons;
  logic [0:0]  n_pad;
  logic [2:0]  n_button;

  logic [15:0] w0 = '0, w1 = '0;
  logic [7:0]  nw = '0;
  int          sh_idx = 0, n_idx = 0;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  snes_pad_reader #(.NUM_PADS(2), .NUM_BITS(16), .HALF_BIT_CYCLES(4),
                    .LATCH_HALF_PERIODS(2), .POLL_CYCLES(400)) dut (
    .clk(clk), .rst(rst), .pad_data(pad_data), .pad_clk(pad_clk), .pad_latch(pad_latch),
    .buttons(buttons), .frame_done(frame_done), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_pad(ev_pad), .ev_button(ev_button), .ev_pressed(ev_pressed), .overflow(overflow));

  snes_pad_reader #(.NUM_PADS(1), .NUM_BITS(8), .HALF_BIT_CYCLES(4),
                    .LATCH_HALF_PERIODS(2), .POLL_CYCLES(400)) nes (
    .clk(clk), .rst(rst), .pad_data(n_data), .pad_clk(n_clk), .pad_latch(n_latch),
    .buttons(n_buttons), .frame_done(n_fd), .ev_valid(n_valid), .ev_ready(n_ready),
    .ev_pad(n_pad), .ev_button(n_button), .ev_pressed(n_pressed), .overflow(n_ovf));

  // Pad models: latch reloads bit 0, each rising pad clock presents the next bit.
  always @(posedge pad_clk or posedge pad_latch)
    if (pad_latch) sh_idx <= 0; else sh_idx <= sh_idx + 1;
  always @(posedge n_clk or posedge n_latch)
    if (n_latch) n_idx <= 0; else n_idx <= n_idx + 1;

  always_comb begin
    pad_data[0] = (sh_idx < NB) ? ~w0[sh_idx[3:0]] : 1'b1;
    pad_data[1] = (sh_idx < NB) ? ~w1[sh_idx[3:0]] : 1'b1;
    n_data[0]   = (n_idx < 8)   ? ~nw[n_idx[2:0]]  : 1'b1;
  end

  ev_t q[$];
  ev_t nq[$];
  int  fd_cnt = 0, latch_rises = 0, n_falls = 0, n_pulses_last = 0;
  bit  overlap_err = 1'b0, stall_err = 1'b0, b2b_err = 1'b0;
  logic       p_valid = 1'b0, p_ready = 1'b0, prev_latch = 1'b0, n_prev_clk = 1'b1;
  logic [8:0] p_payload = '0;

  always @(negedge clk) begin
    if ((pad_latch && !pad_clk) || (n_latch && !n_clk)) overlap_err <= 1'b1;
    if (!rst && p_valid && !p_ready && (!ev_valid || {ev_pad, ev_button, ev_pressed} != p_payload[5:0]))
      stall_err <= 1'b1;
    if (!rst && p_valid && p_ready && ev_valid) b2b_err <= 1'b1;
    if (ev_valid && ev_ready) q.push_back('{pad: int'(ev_pad), btn: int'(ev_button), pr: int'(ev_pressed)});
    if (n_valid && n_ready) nq.push_back('{pad: int'(n_pad), btn: int'(n_button), pr: int'(n_pressed)});
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (pad_latch && !prev_latch) latch_rises <= latch_rises + 1;
    if (n_latch) n_falls <= 0;
    else if (!n_clk && n_prev_clk) n_falls <= n_falls + 1;
    if (n_fd) n_pulses_last <= n_falls;
    p_valid    <= ev_valid;
    p_ready    <= ev_ready;
    p_payload  <= {3'b000, ev_pad, ev_button, ev_pressed};
    prev_latch <= pad_latch;
    n_prev_clk <= n_clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int evc(input int p, input int b, input int r);
    return p * 'h1000 + b * 'h10 + r;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string nm, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin cyc1(); n++; end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL %s: frame_done timeout", nm);
    end
  endtask

  task automatic wait_latch(input string nm, output int n);
    n = 0;
    while (pad_latch !== 1'b1 && n < 1000) begin cyc1(); n++; end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL %s: pad_latch timeout", nm);
    end
  endtask

  logic [31:0] model_prev = '0;

  task automatic run_frame(input vec_t v, input int vi);
    int n, base, fd0, k;
    w0 = v.w0; w1 = v.w1;
    base = q.size(); fd0 = fd_cnt;
    wait_fd($sformatf("v%0d_frame", vi), n);
    chk($sformatf("v%0d_buttons", vi), buttons, v.exp);
    repeat (100) cyc1();
    chk($sformatf("v%0d_frame_done_count", vi), fd_cnt - fd0, 1);
    chk($sformatf("v%0d_event_count", vi), q.size() - base, v.nev);
    k = base;
    for (int i = 0; i < 32; i++) begin
      if (model_prev[i] !== v.exp[i]) begin
        if (k < q.size())
          chk($sformatf("v%0d_event%0d", vi, k - base), evc(q[k].pad, q[k].btn, q[k].pr),
              evc(i / 16, i % 16, int'(v.exp[i])));
        k++;
      end
    end
    model_prev = v.exp;
  endtask

  vec_t vt[6];
  int   n, w, pulses, lw, wmin, wmax, base, fd0, lr0, falls, nbase;
  logic prevc;

  initial begin
    vt[0] = '{16'h0008, 16'h0000, 32'h0000_0008, 1};
    vt[1] = '{16'h0008, 16'h0000, 32'h0000_0008, 0};
    vt[2] = '{16'h0000, 16'h8001, 32'h8001_0000, 3};
    vt[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 30};
    vt[4] = '{16'hA5A5, 16'h0F0F, 32'h0F0F_A5A5, 16};
    vt[5] = '{16'h0000, 16'h0000, 32'h0000_0000, 16};

    w0 = vt[0].w0; w1 = vt[0].w1;
    repeat (3) cyc1();
    chk("rst_pad_clk", pad_clk, 1'b1);
    chk("rst_pad_latch", pad_latch, 1'b0);
    chk("rst_buttons", buttons, 32'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_ev_payload", {ev_pad, ev_button, ev_pressed}, 6'h0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_nes_buttons", n_buttons, 8'h0);
    rst = 1'b0;

    // Single press, with detailed latch / pad clock timing.
    wait_latch("first_tick", n);
    chk("first_tick_latency", n, 400);
    w = 0;
    while (pad_latch === 1'b1 && w < 100) begin cyc1(); w++; end
    chk("latch_width", w, 8);
    chk("pad_clk_after_latch", pad_clk, 1'b1);
    n = 0; pulses = 0; lw = 0; wmin = 999; wmax = 0; prevc = 1'b1;
    while (frame_done !== 1'b1 && n < 400) begin
      cyc1(); n++;
      if (pad_clk === 1'b0) lw++;
      else if (prevc === 1'b0) begin
        pulses++;
        if (lw < wmin) wmin = lw;
        if (lw > wmax) wmax = lw;
        lw = 0;
      end
      prevc = pad_clk;
    end
    chk("shift_cycles", n, 128);
    chk("pad_clk_pulses", pulses, 16);
    chk("pad_clk_low_min", wmin, 4);
    chk("pad_clk_low_max", wmax, 4);
    chk("v0_buttons", buttons, vt[0].exp);
    cyc1();
    chk("frame_done_one_cycle", frame_done, 1'b0);
    repeat (100) cyc1();
    chk("v0_event_count", q.size(), 1);
    if (q.size() > 0) chk("v0_event0", evc(q[0].pad, q[0].btn, q[0].pr), 'h0031);
    model_prev = vt[0].exp;

    for (int i = 1; i < 6; i++) begin
      base = q.size();
      run_frame(vt[i], i);
      if (i == 2 && q.size() >= base + 3) begin
        chk("order_ev0", evc(q[base].pad, q[base].btn, q[base].pr), 'h0030);
        chk("order_ev1", evc(q[base+1].pad, q[base+1].btn, q[base+1].pr), 'h1001);
        chk("order_ev2", evc(q[base+2].pad, q[base+2].btn, q[base+2].pr), 'h10F1);
      end
    end

    // Backpressure: payload must hold while ev_ready is low.
    run_frame('{16'h0008, 16'h0000, 32'h0000_0008, 1}, 6);
    w0 = 16'h0000; w1 = 16'h8001; ev_ready = 1'b0; base = q.size();
    wait_fd("bp_frame", n);
    chk("bp_buttons", buttons, 32'h8001_0000);
    n = 0;
    while (ev_valid !== 1'b1 && n < 100) begin cyc1(); n++; end
    repeat (20) cyc1();
    chk("bp_valid_held", ev_valid, 1'b1);
    chk("bp_payload_held", {ev_pad, ev_button, ev_pressed}, {1'b0, 4'd3, 1'b0});
    chk("bp_none_taken", q.size() - base, 0);
    ev_ready = 1'b1;
    repeat (60) cyc1();
    chk("bp_event_count", q.size() - base, 3);
    if (q.size() >= base + 3) begin
      chk("bp_ev0", evc(q[base].pad, q[base].btn, q[base].pr), 'h0030);
      chk("bp_ev1", evc(q[base+1].pad, q[base+1].btn, q[base+1].pr), 'h1001);
      chk("bp_ev2", evc(q[base+2].pad, q[base+2].btn, q[base+2].pr), 'h10F1);
    end

    // Overflow: a tick during a stalled EMIT is dropped and flagged.
    w0 = 16'h0008; w1 = 16'h0000; ev_ready = 1'b0;
    base = q.size(); lr0 = latch_rises; fd0 = fd_cnt;
    wait_fd("ovf_frame", n);
    chk("ovf_before", overflow, 1'b0);
    repeat (450) cyc1();
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_no_new_latch", latch_rises - lr0, 1);
    chk("ovf_no_events_yet", q.size() - base, 0);
    ev_ready = 1'b1;
    wait_fd("ovf_resume", n);
    chk("ovf_resume_latency", n, 350);
    repeat (100) cyc1();
    chk("ovf_event_count", q.size() - base, 3);
    if (q.size() >= base + 3) begin
      chk("ovf_ev0", evc(q[base].pad, q[base].btn, q[base].pr), 'h0031);
      chk("ovf_ev1", evc(q[base+1].pad, q[base+1].btn, q[base+1].pr), 'h1000);
      chk("ovf_ev2", evc(q[base+2].pad, q[base+2].btn, q[base+2].pr), 'h10F0);
    end
    chk("ovf_frames", fd_cnt - fd0, 2);
    chk("ovf_sticky", overflow, 1'b1);

    // Asynchronous reset in the middle of the 5th pad clock low pulse.
    w1 = 16'h0002;
    wait_latch("rst_latch", n);
    w = 0;
    while (pad_latch === 1'b1 && w < 100) begin cyc1(); w++; end
    n = 0; falls = 0; prevc = 1'b1;
    while (falls < 5 && n < 400) begin
      cyc1(); n++;
      if (pad_clk === 1'b0 && prevc === 1'b1) falls++;
      prevc = pad_clk;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_pad_clk", pad_clk, 1'b1);
    chk("async_pad_latch", pad_latch, 1'b0);
    chk("async_buttons", buttons, 32'h0);
    chk("async_overflow", overflow, 1'b0);
    chk("async_ev_valid", ev_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = q.size();
    wait_latch("post_rst_tick", n);
    chk("post_rst_tick_latency", n, 400);
    wait_fd("post_rst_frame", n);
    chk("post_rst_buttons", buttons, 32'h0002_0008);
    repeat (100) cyc1();
    chk("post_rst_event_count", q.size() - base, 2);
    if (q.size() >= base + 2) begin
      chk("post_rst_ev0", evc(q[base].pad, q[base].btn, q[base].pr), 'h0031);
      chk("post_rst_ev1", evc(q[base+1].pad, q[base+1].btn, q[base+1].pr), 'h1011);
    end

    // NES configuration: one pad, eight bits.
    nw = 8'h80; nbase = nq.size();
    n = 0;
    while (n_fd !== 1'b1 && n < 1000) begin cyc1(); n++; end
    chk("nes_frame_seen", n < 1000, 1'b1);
    chk("nes_buttons", n_buttons, 8'h80);
    repeat (60) cyc1();
    chk("nes_pulses", n_pulses_last, 8);
    chk("nes_event_total", nq.size(), 1);
    if (nq.size() > nbase)
      chk("nes_ev0", evc(nq[nbase].pad, nq[nbase].btn, nq[nbase].pr), 'h0071);
    chk("nes_overflow", n_ovf, 1'b0);

    chk("latch_clk_overlap", overlap_err, 1'b0);
    chk("stall_payload_stable", stall_err, 1'b0);
    chk("valid_drops_after_accept", b2b_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
